// File: rtl/rv_dec_pkg.sv
// rtl/rv_dec_pkg.sv - shared types, opcode constants and immediate-format helper for the RISC-V decode stage
package rv_dec_pkg;

    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_ALUI   = 7'b0010011;
    localparam logic [6:0] OPCODE_ALU    = 7'b0110011;
    localparam logic [6:0] OPCODE_MEM    = 7'b0001111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPCODE_ALUIW  = 7'b0011011;
    localparam logic [6:0] OPCODE_ALUW   = 7'b0111011;

    typedef enum logic [12:0] {
        OPC_NONE   = 13'h0000,
        OPC_LUI    = 13'h0001,
        OPC_AUIPC  = 13'h0002,
        OPC_JAL    = 13'h0004,
        OPC_JALR   = 13'h0008,
        OPC_BRANCH = 13'h0010,
        OPC_LOAD   = 13'h0020,
        OPC_STORE  = 13'h0040,
        OPC_ALUI   = 13'h0080,
        OPC_ALU    = 13'h0100,
        OPC_MEM    = 13'h0200,
        OPC_SYSTEM = 13'h0400,
        OPC_ALUIW  = 13'h0800,
        OPC_ALUW   = 13'h1000
    } opc_t;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_t;

    // imm is held at the widest XLEN already sign-extended; narrower stages keep the low bits
    typedef struct packed {
        opc_t                  opc;
        logic [4:0]            rd;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic                  rd_en;
        logic                  rs1_en;
        logic                  rs2_en;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
        logic [XLEN_MAX-1:0]   imm;
        logic                  ill;
    } dec_bundle_t;

    function automatic imm_fmt_t imm_fmt_of(input opc_t opc);
        case (opc)
            OPC_JALR, OPC_LOAD, OPC_ALUI, OPC_ALUIW, OPC_SYSTEM: return FMT_I;
            OPC_STORE:                                          return FMT_S;
            OPC_BRANCH:                                         return FMT_B;
            OPC_LUI, OPC_AUIPC:                                 return FMT_U;
            OPC_JAL:                                            return FMT_J;
            default:                                            return FMT_R;
        endcase
    endfunction

endpackage

// File: rtl/rv_dec_comb.sv
// rtl/rv_dec_comb.sv - combinational instruction decoder; RV_DEC_STRICT_CHK_EN adds funct-field legality checks
module rv_dec_comb
    import rv_dec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]  ir,
    output dec_bundle_t  dec
);

    opc_t                opc;
    logic [XLEN_MAX-1:0] imm;
    logic                strict_ill;
    logic                writes_rd;
    logic [2:0]          f3;
    logic [6:0]          f7;

    assign f3 = ir[14:12];
    assign f7 = ir[31:25];

    always_comb begin
        case (ir[6:0])
            OPCODE_LUI:    opc = OPC_LUI;
            OPCODE_AUIPC:  opc = OPC_AUIPC;
            OPCODE_JAL:    opc = OPC_JAL;
            OPCODE_JALR:   opc = OPC_JALR;
            OPCODE_BRANCH: opc = OPC_BRANCH;
            OPCODE_LOAD:   opc = OPC_LOAD;
            OPCODE_STORE:  opc = OPC_STORE;
            OPCODE_ALUI:   opc = OPC_ALUI;
            OPCODE_ALU:    opc = OPC_ALU;
            OPCODE_MEM:    opc = OPC_MEM;
            OPCODE_SYSTEM: opc = OPC_SYSTEM;
            OPCODE_ALUIW:  opc = OPC_ALUIW;
            OPCODE_ALUW:   opc = OPC_ALUW;
            default:       opc = OPC_NONE;
        endcase
    end

    always_comb begin
        case (imm_fmt_of(opc))
            FMT_I:   imm = {{52{ir[31]}}, ir[31:20]};
            FMT_S:   imm = {{52{ir[31]}}, ir[31:25], ir[11:7]};
            FMT_B:   imm = {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            FMT_U:   imm = {{32{ir[31]}}, ir[31:12], 12'h000};
            FMT_J:   imm = {{43{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

`ifdef RV_DEC_STRICT_CHK_EN
    // RV64 shift amounts are 6 bits wide, so only imm[11:6] must be clean there
    always_comb begin
        strict_ill = 1'b0;
        case (opc)
            OPC_ALU, OPC_ALUW:
                strict_ill = !(f7 == 7'h00 || f7 == 7'h20) ||
                             (f7 == 7'h20 && !(f3 == 3'b000 || f3 == 3'b101));
            OPC_ALUI:
                if (f3 == 3'b001)
                    strict_ill = (XLEN == 32) ? (ir[31:25] != 7'h00) : (ir[31:26] != 6'h00);
                else if (f3 == 3'b101)
                    strict_ill = (XLEN == 32) ? !(ir[31:25] == 7'h00 || ir[31:25] == 7'h20)
                                              : !(ir[31:26] == 6'h00 || ir[31:26] == 6'h10);
            OPC_LOAD:
                strict_ill = (f3 == 3'b111) || ((XLEN == 32) && (f3 == 3'b011 || f3 == 3'b110));
            OPC_STORE:
                strict_ill = (XLEN == 32) ? (f3 > 3'b010) : (f3 > 3'b011);
            OPC_BRANCH:
                strict_ill = (f3 == 3'b010) || (f3 == 3'b011);
            OPC_JALR:
                strict_ill = (f3 != 3'b000);
            default:
                strict_ill = 1'b0;
        endcase
    end
`else
    assign strict_ill = 1'b0;
`endif

    assign writes_rd = opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD,
                                   OPC_ALUI, OPC_ALU, OPC_SYSTEM, OPC_ALUIW, OPC_ALUW};

    always_comb begin
        dec        = '0;
        dec.opc    = opc;
        dec.rd     = ir[11:7];
        dec.rs1    = ir[19:15];
        dec.rs2    = ir[24:20];
        dec.funct3 = f3;
        dec.funct7 = f7;
        dec.imm    = imm;
        dec.rd_en  = writes_rd && (ir[11:7] != 5'd0);
        dec.rs1_en = !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
        dec.rs2_en = opc inside {OPC_BRANCH, OPC_STORE, OPC_ALU, OPC_ALUW};
        dec.ill    = (ir[1:0] != 2'b11) || (opc == OPC_NONE) ||
                     ((opc == OPC_ALUIW || opc == OPC_ALUW) && (XLEN == 32)) || strict_ill;
    end

endmodule

// File: rtl/rv_dec_stage.sv
// rtl/rv_dec_stage.sv - registered decode stage with 2-entry skid buffer; optional RV_DEC_STRICT_CHK_EN in rv_dec_comb
module rv_dec_stage
    import rv_dec_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic [31:0]     in_ir,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [XLEN-1:0] out_pc,
    output opc_t            out_opc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic            out_rd_en,
    output logic            out_rs1_en,
    output logic            out_rs2_en,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic            out_ill
);

    if (DEPTH != 2) begin : g_bad_depth
        $error("rv_dec_stage: DEPTH must be 2");
    end
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("rv_dec_stage: XLEN must be 32 or 64");
    end

    dec_bundle_t     dec;
    dec_bundle_t     ent_q [DEPTH];
    logic [XLEN-1:0] pc_q  [DEPTH];
    logic [1:0]      count;
    logic            wr_ptr;
    logic            rd_ptr;
    logic            push;
    logic            pop;

    rv_dec_comb #(.XLEN(XLEN)) u_dec (
        .ir  (in_ir),
        .dec (dec)
    );

    // ready depends only on the occupancy register, never on out_rdy
    assign in_rdy  = (count != 2'd2);
    assign out_vld = (count != 2'd0);
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
                pc_q[i]  <= '0;
            end
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                ent_q[wr_ptr] <= dec;
                pc_q[wr_ptr]  <= in_pc;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign out_pc     = pc_q[rd_ptr];
    assign out_opc    = ent_q[rd_ptr].opc;
    assign out_rd     = ent_q[rd_ptr].rd;
    assign out_rs1    = ent_q[rd_ptr].rs1;
    assign out_rs2    = ent_q[rd_ptr].rs2;
    assign out_rd_en  = ent_q[rd_ptr].rd_en;
    assign out_rs1_en = ent_q[rd_ptr].rs1_en;
    assign out_rs2_en = ent_q[rd_ptr].rs2_en;
    assign out_funct3 = ent_q[rd_ptr].funct3;
    assign out_funct7 = ent_q[rd_ptr].funct7;
    assign out_imm    = XLEN'(ent_q[rd_ptr].imm);
    assign out_ill    = ent_q[rd_ptr].ill;

endmodule

// File: tb/tb_rv_dec_stage.sv
// tb/tb_rv_dec_stage.sv - bench driving XLEN=32 and XLEN=64 decode stages against a queue-based reference model
module tb_rv_dec_stage;
    import rv_dec_pkg::*;

    localparam logic [6:0]  OPS [13] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23,
                                        7'h13, 7'h33, 7'h0f, 7'h73, 7'h1b, 7'h3b};
    localparam logic [12:0] WR_MASK  = 13'b1_1101_1010_1111;
    localparam logic [12:0] RS2_MASK = 13'b1_0001_0101_0000;

    typedef struct packed {
        logic [12:0] opc;
        logic [4:0]  rd, rs1, rs2;
        logic        rd_en, rs1_en, rs2_en;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic        ill;
    } ref_t;

    typedef struct {
        logic [31:0] ir;
        logic [63:0] pc;
    } item_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_vld, out_rdy;
    logic [31:0] in_ir;
    logic [63:0] pc;

    logic        in_rdy_a, out_vld_a, rd_en_a, rs1_en_a, rs2_en_a, ill_a;
    logic [31:0] out_pc_a, imm_a;
    opc_t        opc_a;
    logic [4:0]  rd_a, rs1_a, rs2_a;
    logic [2:0]  f3_a;
    logic [6:0]  f7_a;

    logic        in_rdy_b, out_vld_b, rd_en_b, rs1_en_b, rs2_en_b, ill_b;
    logic [63:0] out_pc_b, imm_b;
    opc_t        opc_b;
    logic [4:0]  rd_b, rs1_b, rs2_b;
    logic [2:0]  f3_b;
    logic [6:0]  f7_b;

    item_t q[$];
    int    nerr = 0;
    int    nchk = 0;

    always #5 clk = ~clk;

    rv_dec_stage #(.XLEN(32)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy_a),
        .in_ir(in_ir), .in_pc(pc[31:0]), .out_vld(out_vld_a), .out_rdy(out_rdy),
        .out_pc(out_pc_a), .out_opc(opc_a), .out_rd(rd_a), .out_rs1(rs1_a), .out_rs2(rs2_a),
        .out_rd_en(rd_en_a), .out_rs1_en(rs1_en_a), .out_rs2_en(rs2_en_a),
        .out_funct3(f3_a), .out_funct7(f7_a), .out_imm(imm_a), .out_ill(ill_a)
    );

    rv_dec_stage #(.XLEN(64)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy_b),
        .in_ir(in_ir), .in_pc(pc), .out_vld(out_vld_b), .out_rdy(out_rdy),
        .out_pc(out_pc_b), .out_opc(opc_b), .out_rd(rd_b), .out_rs1(rs1_b), .out_rs2(rs2_b),
        .out_rd_en(rd_en_b), .out_rs1_en(rs1_en_b), .out_rs2_en(rs2_en_b),
        .out_funct3(f3_b), .out_funct7(f7_b), .out_imm(imm_b), .out_ill(ill_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic ref_t ref_dec(input logic [31:0] ir, input int xlen);
        ref_t   r;
        int     k;
        longint imm;
        logic [2:0] f3;
        logic [6:0] f7;
        k   = -1;
        imm = 0;
        f3  = ir[14:12];
        f7  = ir[31:25];
        for (int i = 0; i < 13; i++) if (ir[6:0] == OPS[i]) k = i;
        r        = '0;
        r.rd     = ir[11:7];
        r.rs1    = ir[19:15];
        r.rs2    = ir[24:20];
        r.f3     = f3;
        r.f7     = f7;
        case (k)
            3, 5, 7, 10, 11: imm = $signed(ir[31:20]);
            6:               imm = $signed({ir[31:25], ir[11:7]});
            4:               imm = $signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0});
            0, 1:            imm = $signed({ir[31:12], 12'h000});
            2:               imm = $signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0});
            default:         imm = 0;
        endcase
        r.imm    = (xlen == 32) ? {32'h0, imm[31:0]} : imm;
        r.rs1_en = !(k inside {0, 1, 2});
        if (k >= 0) begin
            r.opc    = 13'h0001 << k;
            r.rd_en  = WR_MASK[k] && (ir[11:7] != 5'd0);
            r.rs2_en = RS2_MASK[k];
        end
        r.ill = (ir[1:0] != 2'b11) || (k < 0) || (xlen == 32 && (k == 11 || k == 12));
`ifdef RV_DEC_STRICT_CHK_EN
        case (k)
            8, 12: if (!(f7 inside {7'h00, 7'h20}) || (f7 == 7'h20 && !(f3 inside {3'd0, 3'd5}))) r.ill = 1'b1;
            7: begin
                if (f3 == 3'd1 && (xlen == 32 ? f7 != 7'h00 : ir[31:26] != 6'h00)) r.ill = 1'b1;
                if (f3 == 3'd5 && (xlen == 32 ? !(f7 inside {7'h00, 7'h20})
                                              : !(ir[31:26] inside {6'h00, 6'h10}))) r.ill = 1'b1;
            end
            5: if (f3 == 3'd7 || (xlen == 32 && (f3 == 3'd3 || f3 == 3'd6))) r.ill = 1'b1;
            6: if (int'(f3) > (xlen == 32 ? 2 : 3)) r.ill = 1'b1;
            4: if (f3 == 3'd2 || f3 == 3'd3) r.ill = 1'b1;
            3: if (f3 != 3'd0) r.ill = 1'b1;
            default: ;
        endcase
`endif
        return r;
    endfunction

    task automatic cmp_bundle(input string n, input int xlen, input ref_t o);
        ref_t e;
        e = ref_dec(q[0].ir, xlen);
        chk({n, "_opc"}, 64'(o.opc), 64'(e.opc));
        chk({n, "_rd"}, 64'(o.rd), 64'(e.rd));
        chk({n, "_rs1"}, 64'(o.rs1), 64'(e.rs1));
        chk({n, "_rs2"}, 64'(o.rs2), 64'(e.rs2));
        chk({n, "_en"}, 64'({o.rd_en, o.rs1_en, o.rs2_en}), 64'({e.rd_en, e.rs1_en, e.rs2_en}));
        chk({n, "_funct"}, 64'({o.f7, o.f3}), 64'({e.f7, e.f3}));
        chk({n, "_imm"}, o.imm, e.imm);
        chk({n, "_ill"}, 64'(o.ill), 64'(e.ill));
    endtask

    task automatic check_out();
        chk("a_vld", 64'(out_vld_a), 64'(q.size() > 0));
        chk("a_rdy", 64'(in_rdy_a), 64'(q.size() < 2));
        chk("b_vld", 64'(out_vld_b), 64'(q.size() > 0));
        chk("b_rdy", 64'(in_rdy_b), 64'(q.size() < 2));
        if (q.size() > 0) begin
            chk("a_pc", 64'(out_pc_a), {32'h0, q[0].pc[31:0]});
            chk("b_pc", out_pc_b, q[0].pc);
            cmp_bundle("a", 32, '{opc_a, rd_a, rs1_a, rs2_a, rd_en_a, rs1_en_a, rs2_en_a,
                                  f3_a, f7_a, {32'h0, imm_a}, ill_a});
            cmp_bundle("b", 64, '{opc_b, rd_b, rs1_b, rs2_b, rd_en_b, rs1_en_b, rs2_en_b,
                                  f3_b, f7_b, imm_b, ill_b});
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] ir, input logic r, input logic f);
        logic do_push, do_pop;
        pc      = pc + 64'd4;
        in_vld  = v;
        in_ir   = ir;
        out_rdy = r;
        flush   = f;
        do_push = v && (q.size() < 2);
        do_pop  = r && (q.size() > 0);
        @(posedge clk);
        if (f) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{ir, pc});
        end
        @(negedge clk);
        check_out();
    endtask

    function automatic logic [31:0] rand_ir();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 14);
        if (k < 13) r = {r[31:7], OPS[k]};
        return r;
    endfunction

    initial begin
        logic exp_strict;
        rst = 1'b1; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; in_ir = '0;
        pc  = 64'hFFFF_FFF0_0000_1000;
        @(negedge clk);
        chk("rst_a_vld", 64'(out_vld_a), 64'd0);
        chk("rst_a_rdy", 64'(in_rdy_a), 64'd1);
        chk("rst_b_data", {out_pc_b[31:0], imm_b[31:0]}, 64'd0);
        chk("rst_b_opc", 64'(opc_b), 64'd0);
        rst = 1'b0;

        cycle(1'b1, 32'hFFF0_0093, 1'b1, 1'b0);
        chk("addi_a_imm", 64'(imm_a), 64'hFFFF_FFFF);
        chk("addi_a_opc", 64'(opc_a), 64'(OPC_ALUI));
        cycle(1'b1, 32'h8000_02B7, 1'b1, 1'b0);
        chk("lui_b_imm", imm_b, 64'hFFFF_FFFF_8000_0000);
        chk("lui_b_rs1en", 64'(rs1_en_b), 64'd0);
        cycle(1'b1, 32'hFE00_0EE3, 1'b1, 1'b0);
        chk("beq_b_imm", imm_b, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("beq_b_en", 64'({rd_en_b, rs2_en_b}), 64'b01);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        cycle(1'b1, 32'h0020_8113, 1'b0, 1'b0);
        cycle(1'b1, 32'h0031_81B3, 1'b0, 1'b0);
        chk("full_rdy", 64'(in_rdy_a), 64'd0);
        cycle(1'b1, 32'h0042_2223, 1'b0, 1'b0);
        cycle(1'b1, 32'h0042_2223, 1'b1, 1'b0);
        cycle(1'b1, 32'h0042_2223, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        cycle(1'b1, 32'h0000_006F, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_8067, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0073, 1'b0, 1'b1);
        chk("flush_vld", 64'(out_vld_b), 64'd0);

        cycle(1'b1, 32'h0000_0000, 1'b1, 1'b0);
        chk("zero_ill_opc", 64'({ill_a, 13'(opc_a)}), 64'h2000);
        cycle(1'b1, 32'h0010_809B, 1'b1, 1'b0);
        chk("addiw_ill", 64'({ill_a, ill_b}), 64'b10);
        chk("addiw_b_opc", 64'(opc_b), 64'(OPC_ALUIW));
        cycle(1'b1, 32'h0200_0033, 1'b1, 1'b0);
`ifdef RV_DEC_STRICT_CHK_EN
        exp_strict = 1'b1;
`else
        exp_strict = 1'b0;
`endif
        chk("mul_ill", 64'({ill_a, ill_b}), {62'd0, exp_strict, exp_strict});

        cycle(1'b1, 32'h0010_0093, 1'b0, 1'b0);
        cycle(1'b1, 32'h0010_0113, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_vld", 64'({out_vld_a, out_vld_b}), 64'd0);
        chk("mid_rst_rdy", 64'({in_rdy_a, in_rdy_b}), 64'b11);
        q.delete();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, rand_ir(), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 24) == 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/rv_dec_stage.md
Name: rv_dec_stage

Overview:
- Registered instruction-decode pipeline stage, parametrised over XLEN (32/64).
- Accepts a fetched instruction and its PC over a valid/ready handshake.
- Produces one flattened decode bundle: opcode class, register fields and enables, format-selected sign-extended immediate, illegal flag.
- Sits between fetch and issue/execute; a 2-entry buffer gives full throughput under backpressure.

Parameters:
- XLEN, 32, datapath width; 32 or 64 only. 64 enables the OP-IMM-32 and OP-32 opcodes.
- DEPTH, 2, buffer entries; fixed at 2 (elaboration error otherwise).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  drop all buffered entries
- in_vld  in  1  instruction valid
- in_rdy  out  1  stage can accept
- in_ir  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- out_vld  out  1  decode bundle valid
- out_rdy  in  1  consumer accepts
- out_pc  out  XLEN  PC of bundle
- out_opc  out  opc_t  one-hot opcode class
- out_rd / out_rs1 / out_rs2  out  5 each  register indices
- out_rd_en / out_rs1_en / out_rs2_en  out  1 each  register used
- out_funct3  out  3  funct3
- out_funct7  out  7  funct7
- out_imm  out  XLEN  immediate selected by format
- out_ill  out  1  illegal instruction

Behaviour:
- Reset (async assert, sync deassert to clk): count=0, rd/wr pointers=0, out_vld=0, in_rdy=1; all data outputs 0.
- Push when in_vld&&in_rdy; pop when out_vld&&out_rdy.
- in_rdy = (count<2), registered state only; no combinational path from out_rdy.
- Latency: accepted at edge N, visible on out_* after edge N (1 cycle).
- out_* driven from the read-pointer entry, so outputs are stable while out_vld&&!out_rdy.
- Decode happens before the buffer write; stored entries are decoded bundles.
- Push+pop same cycle: count unchanged. count=2: no push. count=0: out_vld=0. Pointers wrap mod 2.
- flush: count=0 and pointers=0 next cycle; a push in the flush cycle is discarded; highest priority after reset.
- Opcode classes (one-hot): LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ALUI, ALU, MEM, SYSTEM, ALUIW, ALUW. At most one bit set; unknown opcode gives all-zero plus ill=1.
- Immediate by class, sign-extended to XLEN from the MSB of the format:
  - I: JALR, LOAD, ALUI, ALUIW, SYSTEM
  - S: STORE
  - B: BRANCH, bit0=0
  - U: LUI, AUIPC; low 12 bits=0; bit 31 sign-extends when XLEN=64
  - J: JAL
  - R-type and MEM: imm=0
- Enables:
  - rd_en = class writes rd && rd!=0.
  - rs1_en = not LUI/AUIPC/JAL.
  - rs2_en = BRANCH/STORE/ALU/ALUW.
- ill=1 when any of:
  - ir[1:0]!=2'b11
  - unknown opcode
  - ALUIW/ALUW with XLEN=32
- Illegal entries are still buffered and presented; the consumer traps.

Optional Feature:
- Macro RV_DEC_STRICT_CHK_EN.
- Defined: ill additionally set for
  - ALU/ALUW with funct7 not in {0x00,0x20}, or 0x20 with funct3 not in {ADD/SUB, SRA}
  - ALUI shifts with illegal imm[11:5] (imm[11:6] when XLEN=64)
  - LOAD funct3 in {3'b011(XLEN=32), 3'b110(XLEN=32), 3'b111}
  - STORE funct3 > 3'b010 (>3'b011 for XLEN=64)
  - BRANCH funct3 in {3'b010, 3'b011}
  - JALR funct3!=0
- Undefined: only the base rules in Behaviour apply.

Decomposition:
- Package rv_dec_pkg: opc_t one-hot enum, OPCODE_* constants (including OPCODE_ALUIW 7'b0011011, OPCODE_ALUW 7'b0111011), imm format enum, dec_bundle_t struct parametrised via XLEN-sized fields.
- One combinational sub-module rv_dec_comb (ir → dec_bundle_t, XLEN param); the stage module owns the buffer and handshake.

Test Plan:
- XLEN=32, push 0xFFF00093 (addi x1,x0,-1) → next cycle out_vld=1, ALUI, rd=1, rd_en=1, rs1_en=1, imm=0xFFFFFFFF, ill=0.
- XLEN=64, push 0x800002B7 (lui x5,0x80000) → imm=0xFFFFFFFF80000000, rd=5, rs1_en=0; push 0xFE000EE3 (beq x0,x0,-4) → imm=-4, rd_en=0, rs2_en=1.
- out_rdy=0, push 3 back-to-back → in_rdy=0 after 2 accepted; third held; release out_rdy → bundles emerge in order, one per cycle, no loss.
- Two entries buffered, assert flush with in_vld=1 → next cycle out_vld=0, in_rdy=1, flushed push absent.
- Push 0x00000000 → ill=1, opc=0. XLEN=32 push 0x0010809B (addiw) → ill=1; XLEN=64 → ALUIW, ill=0.
- Push 0x02000033 (funct7=0x01) → ill=1 with RV_DEC_STRICT_CHK_EN, ill=0 without; assert rst mid-stream → out_vld=0 immediately.
